// File: rtl/sparse_mac_acc_4bit.sv
`default_nettype none
// ============================================================================
// Module      : sparse_mac_acc_4bit
// Description : Multiply-accumulate engine for one output channel of a sparse
//               4-bit layer. Consumes compressed (weight, activation) pairs,
//               multiplies them in a product register, and sums the products
//               into an XW-bit signed saturating accumulator. The finished
//               sum is handed to the downstream BN/quant stage (bn_quant_4bit,
//               as X_in) over a valid/ready handshake. Only one vector is in
//               flight at a time.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XW          accumulator / result width (must match bn_quant_4bit XW, >= 8)
//   SIGNED_MODE 1: activations signed (-8..7), 0: unsigned (0..15)
//   CW          width of the beat counter out_cnt
// Ports
//   clk        in   1   clock, all logic on the rising edge
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   input beat valid
//   in_ready   out  1   block can accept a beat
//   in_w       in   4   signed weight
//   in_a       in   4   activation (signedness per SIGNED_MODE)
//   in_last    in   1   final beat of the current vector
//   out_valid  out  1   result valid
//   out_ready  in   1   downstream accepts the result
//   out_acc    out  XW  signed accumulated sum
//   out_sat    out  1   saturation occurred somewhere within this vector
//   out_cnt    out  CW  beats in the vector (saturates at all-ones)
// ============================================================================
module sparse_mac_acc_4bit #(
  parameter int XW          = 22,
  parameter bit SIGNED_MODE = 1'b1,
  parameter int CW          = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_w,
  input  logic [3:0]           in_a,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [XW-1:0] out_acc,
  output logic                 out_sat,
  output logic [CW-1:0]        out_cnt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [XW-1:0] ACC_MAX = {1'b0, {(XW-1){1'b1}}};
  localparam logic [XW-1:0] ACC_MIN = {1'b1, {(XW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Control FSM
  //   IDLE  : waiting for the first beat of a vector
  //   ACC   : beats of the current vector are being accepted
  //   FLUSH : last product sits in the product register, being accumulated
  //   HOLD  : result presented, waiting for downstream to take it
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;

  assign in_ready = (state == IDLE) || (state == ACC);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_nxt = in_last ? FLUSH : ACC;
        end
      end
      FLUSH: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stage 1: operand extension and product register
  // --------------------------------------------------------------------------
  logic signed [8:0] w_ext;
  logic signed [8:0] a_ext;
  logic signed [8:0] prod_nxt;

  logic signed [8:0] prod;
  logic              p_vld;
  logic              p_last;

  assign w_ext = {{5{in_w[3]}}, in_w};

  generate
    if (SIGNED_MODE) begin : g_act_signed
      assign a_ext = {{5{in_a[3]}}, in_a};
    end else begin : g_act_unsigned
      assign a_ext = {5'b00000, in_a};
    end
  endgenerate

  // Worst-case magnitudes (-8*-8 = 64, -8*15 = -120) fit in 9 signed bits,
  // so the truncated 9-bit product is exact.
  assign prod_nxt = w_ext * a_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod   <= '0;
      p_vld  <= 1'b0;
      p_last <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        prod   <= prod_nxt;
        p_last <= in_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: saturating accumulator
  // The sum is formed one bit wider than the accumulator; the top two bits
  // disagreeing means the true sum left the XW-bit range.
  // --------------------------------------------------------------------------
  logic [XW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          sat;

  logic [XW:0]   acc_ext;
  logic [XW:0]   prod_ext;
  logic [XW:0]   sum;
  logic          sat_hit;
  logic [XW-1:0] clamped;
  logic [CW-1:0] cnt_inc;
  logic          sat_nxt;

  assign acc_ext = {acc[XW-1], acc};

  generate
    if (XW > 8) begin : g_pext_wide
      assign prod_ext = {{(XW-8){prod[8]}}, prod};
    end else begin : g_pext_exact
      assign prod_ext = prod[XW:0];
    end
  endgenerate

  assign sum     = acc_ext + prod_ext;
  assign sat_hit = sum[XW] ^ sum[XW-1];
  assign clamped = !sat_hit ? sum[XW-1:0] : (sum[XW] ? ACC_MIN : ACC_MAX);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);
  assign sat_nxt = sat | sat_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (p_vld) begin
        if (p_last) begin
          // Publish the result and leave the running state clean for the
          // next vector, so nothing carries over between vectors.
          out_acc   <= clamped;
          out_sat   <= sat_nxt;
          out_cnt   <= cnt_inc;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          sat       <= 1'b0;
        end else begin
          acc <= clamped;
          cnt <= cnt_inc;
          sat <= sat_nxt;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sparse_mac_acc_4bit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sparse_mac_acc_4bit
// Description : Self-checking bench. Three instances share one stimulus
//               stream: signed XW=22, unsigned XW=22 and signed XW=8. A
//               behavioural model pushes expected results into per-instance
//               queues as beats are accepted; a monitor pops and compares
//               on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sparse_mac_acc_4bit;

  localparam int CW = 10;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_w = 4'd0;
  logic [3:0] in_a = 4'd0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic                 ov   [3];
  logic                 ir   [3];
  logic                 osat [3];
  logic [CW-1:0]        ocnt [3];
  logic signed [63:0]   oacc [3];
  logic signed [21:0]   s_acc;
  logic signed [21:0]   u_acc;
  logic signed [7:0]    n_acc;

  assign oacc[0] = {{42{s_acc[21]}}, s_acc};
  assign oacc[1] = {{42{u_acc[21]}}, u_acc};
  assign oacc[2] = {{56{n_acc[7]}},  n_acc};

  always #5 clk = ~clk;

  sparse_mac_acc_4bit #(.XW(22), .SIGNED_MODE(1'b1), .CW(CW)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_w(in_w), .in_a(in_a), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .out_acc(s_acc), .out_sat(osat[0]), .out_cnt(ocnt[0])
  );

  sparse_mac_acc_4bit #(.XW(22), .SIGNED_MODE(1'b0), .CW(CW)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_w(in_w), .in_a(in_a), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .out_acc(u_acc), .out_sat(osat[1]), .out_cnt(ocnt[1])
  );

  sparse_mac_acc_4bit #(.XW(8), .SIGNED_MODE(1'b1), .CW(CW)) u_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_w(in_w), .in_a(in_a), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .out_acc(n_acc), .out_sat(osat[2]), .out_cnt(ocnt[2])
  );

  // --------------------------------------------------------------------------
  // Model and scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    longint acc;
    bit     sat;
    int     cnt;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];

  int     m_xw [3] = '{22, 22, 8};
  bit     m_sm [3] = '{1'b1, 1'b0, 1'b1};
  longint m_acc[3] = '{0, 0, 0};
  bit     m_sat[3] = '{1'b0, 1'b0, 1'b0};
  int     m_cnt[3] = '{0, 0, 0};

  int checks   = 0;
  int failures = 0;

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_acc[d] = 0;
      m_sat[d] = 1'b0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic model_beat(input logic [3:0] w, input logic [3:0] a, input bit last);
    longint wi, ai, s, mx, mn;
    res_t r;
    for (int d = 0; d < 3; d++) begin
      wi = w[3] ? longint'(w) - 16 : longint'(w);
      ai = (m_sm[d] && a[3]) ? longint'(a) - 16 : longint'(a);
      s  = m_acc[d] + wi * ai;
      mx = (longint'(1) <<< (m_xw[d] - 1)) - 1;
      mn = -mx - 1;
      if (s > mx) begin
        s = mx;
        m_sat[d] = 1'b1;
      end else if (s < mn) begin
        s = mn;
        m_sat[d] = 1'b1;
      end
      if (m_cnt[d] < CNT_MAX) m_cnt[d] = m_cnt[d] + 1;
      if (last) begin
        r.acc = s;
        r.sat = m_sat[d];
        r.cnt = m_cnt[d];
        case (d)
          0:       q0.push_back(r);
          1:       q1.push_back(r);
          default: q2.push_back(r);
        endcase
        m_acc[d] = 0;
        m_sat[d] = 1'b0;
        m_cnt[d] = 0;
      end else begin
        m_acc[d] = s;
      end
    end
  endtask

  // Output monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && out_ready) begin
          res_t e;
          bit   empty;
          empty = 1'b0;
          e.acc = 0;
          e.sat = 1'b0;
          e.cnt = 0;
          case (d)
            0:       if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
            1:       if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
            default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
          endcase
          checks++;
          if (empty) begin
            failures++;
            $display("FAIL unexpected_result dut%0d: acc=%0d sat=%0b cnt=%0d with nothing expected",
                     d, oacc[d], osat[d], ocnt[d]);
          end else if (oacc[d] !== e.acc || osat[d] !== e.sat || ocnt[d] !== e.cnt) begin
            failures++;
            $display("FAIL result dut%0d: got acc=%0d sat=%0b cnt=%0d, want acc=%0d sat=%0b cnt=%0d",
                     d, oacc[d], osat[d], ocnt[d], e.acc, e.sat, e.cnt);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 ns after a rising edge)
  // --------------------------------------------------------------------------
  task automatic send_beat(input int w, input int a, input bit last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_w     = 4'(w);
    in_a     = 4'(a);
    in_last  = last;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (ir[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%0b, want 1 within 64 cycles", ir[0]);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_beat(4'(w), 4'(a), last);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d/%0d/%0d, want 0/0/0", q0.size(), q1.size(), q2.size());
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;            // presented during reset: must be ignored
    in_w     = 4'd7;
    in_a     = 4'd7;
    in_last  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || oacc[d] !== 0 || osat[d] !== 1'b0 || ocnt[d] !== 0 || ir[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset dut%0d: got v=%0b acc=%0d sat=%0b cnt=%0d rdy=%0b, want 0/0/0/0/1",
                 d, ov[d], oacc[d], osat[d], ocnt[d], ir[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_output: out_valid=%0b, want 0", ov[0]);
    end
  endtask

  task automatic test_signed_basic();
    out_ready = 1'b1;
    send_beat(7, 7, 1'b0);
    send_beat(-8, -8, 1'b0);
    send_beat(3, -2, 1'b1);
    checks++;
    if (ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: out_valid=%0b one edge after last beat, want 0", ov[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b1 || oacc[0] !== 107 || ocnt[0] !== 3 || osat[0] !== 1'b0) begin
      failures++;
      $display("FAIL signed_basic: got v=%0b acc=%0d cnt=%0d sat=%0b, want 1/107/3/0",
               ov[0], oacc[0], ocnt[0], osat[0]);
    end
    wait_drain();
  endtask

  task automatic test_unsigned();
    send_beat(-8, 15, 1'b0);
    send_beat(7, 15, 1'b1);
    for (int n = 0; n < 8 && !ov[1]; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ov[1] !== 1'b1 || oacc[1] !== -15 || ocnt[1] !== 2) begin
      failures++;
      $display("FAIL unsigned_two: got v=%0b acc=%0d cnt=%0d, want 1/-15/2", ov[1], oacc[1], ocnt[1]);
    end
    wait_drain();
    send_beat(-8, 15, 1'b1);
    for (int n = 0; n < 8 && !ov[1]; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ov[1] !== 1'b1 || oacc[1] !== -120 || ocnt[1] !== 1) begin
      failures++;
      $display("FAIL unsigned_single: got v=%0b acc=%0d cnt=%0d, want 1/-120/1", ov[1], oacc[1], ocnt[1]);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    bit seen;
    out_ready = 1'b0;
    send_beat(7, 7, 1'b0);
    send_beat(-8, -8, 1'b0);
    send_beat(3, -2, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (ov[0]) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_valid_timeout: out_valid=%0b, want 1", ov[0]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || oacc[0] !== 107 || ocnt[0] !== 3 || ir[0] !== 1'b0 ||
          ov[2] !== 1'b1 || ir[1] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc%0d: got v=%0b acc=%0d cnt=%0d rdy=%0b, want 1/107/3/0",
                 c, ov[0], oacc[0], ocnt[0], ir[0]);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got v=%0b rdy=%0b after transfer, want 0/1", ov[0], ir[0]);
    end
    send_beat(1, 1, 1'b1);
    wait_drain();
  endtask

  task automatic test_saturation();
    send_beat(-8, -8, 1'b0);
    send_beat(-8, -8, 1'b0);
    send_beat(-8, -8, 1'b1);
    for (int n = 0; n < 8 && !ov[2]; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ov[2] !== 1'b1 || oacc[2] !== 127 || osat[2] !== 1'b1 || ocnt[2] !== 3) begin
      failures++;
      $display("FAIL sat_clamp: got v=%0b acc=%0d sat=%0b cnt=%0d, want 1/127/1/3",
               ov[2], oacc[2], osat[2], ocnt[2]);
    end
    wait_drain();
    send_beat(2, 3, 1'b1);
    for (int n = 0; n < 8 && !ov[2]; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ov[2] !== 1'b1 || oacc[2] !== 6 || osat[2] !== 1'b0) begin
      failures++;
      $display("FAIL sat_cleared: got v=%0b acc=%0d sat=%0b, want 1/6/0", ov[2], oacc[2], osat[2]);
    end
    wait_drain();
  endtask

  task automatic test_bubbles();
    int ws[3] = '{7, -8, 3};
    int as[3] = '{7, -8, -2};
    for (int v = 0; v < 3; v++) begin
      for (int b = 0; b < 3; b++) begin
        send_beat(ws[b], as[b], b == 2);
        if (b < 2) begin
          in_w    = 4'($urandom);
          in_a    = 4'($urandom);
          in_last = 1'($urandom);
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      for (int n = 0; n < 8 && !ov[0]; n++) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (ov[0] !== 1'b1 || oacc[0] !== 107 || ocnt[0] !== 3) begin
        failures++;
        $display("FAIL bubbles v%0d: got v=%0b acc=%0d cnt=%0d, want 1/107/3", v, ov[0], oacc[0], ocnt[0]);
      end
      wait_drain();
    end
  endtask

  task automatic test_reset_mid();
    send_beat(7, 7, 1'b0);
    send_beat(7, 7, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_w     = 4'd7;
    in_a     = 4'd7;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || oacc[d] !== 0 || osat[d] !== 1'b0 || ocnt[d] !== 0 || ir[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid dut%0d: got v=%0b acc=%0d sat=%0b cnt=%0d rdy=%0b, want 0/0/0/0/1",
                 d, ov[d], oacc[d], osat[d], ocnt[d], ir[d]);
      end
    end
    send_beat(1, 1, 1'b1);
    for (int n = 0; n < 8 && !ov[0]; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ov[0] !== 1'b1 || oacc[0] !== 1 || ocnt[0] !== 1) begin
      failures++;
      $display("FAIL reset_mid_next: got v=%0b acc=%0d cnt=%0d, want 1/1/1", ov[0], oacc[0], ocnt[0]);
    end
    wait_drain();
  endtask

  task automatic test_cnt_saturate();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      send_beat(0, (i % 15) - 7, 1'b0);
    end
    send_beat(1, 2, 1'b1);
    for (int n = 0; n < 8 && !ov[0]; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ov[0] !== 1'b1 || ocnt[0] !== CNT_MAX || oacc[0] !== 2) begin
      failures++;
      $display("FAIL cnt_saturate: got v=%0b cnt=%0d acc=%0d, want 1/%0d/2", ov[0], ocnt[0], oacc[0], CNT_MAX);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_unsigned();
    test_backpressure();
    test_saturation();
    test_bubbles();
    test_reset_mid();
    test_cnt_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
